// File: rtl/store_pkg.sv
// Shared types and helpers for the sw/sh/sb store unit.
// Holds the size and state encodings plus the request alignment rules.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } store_state_t;

  localparam int MEM_LATENCY_MAX = 4;
  localparam int CNT_W           = 3;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned for that size.
  function automatic logic request_misaligned(input store_size_t sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input store_size_t sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational lane merge: overlays the store data onto the old memory word
// in little-endian byte lanes selected by size and offset.
module byte_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  logic [3:0]  lane_en;
  logic [31:0] src;

  assign lane_en = lane_mask(store_size_t'(size), offset);

  // Replicate the right-justified data so every lane sees its candidate byte.
  always_comb begin
    src = wdata;
    case (size)
      SZ_BYTE: src = {4{wdata[7:0]}};
      SZ_HALF: src = {2{wdata[15:0]}};
      default: src = wdata;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = lane_en[gi] ? src[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/store_unit.sv
// Store sequencer for a 32-bit memory: direct word writes, read-modify-write
// for bytes and halfwords. Every output is a register; start never reaches mem_wr combinationally.
module store_unit
  import store_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
);

  localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                       (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LAT - 1);

  store_state_t     state_q;
  store_size_t      size_q;
  logic [1:0]       offset_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             misaligned_q;
  logic             mem_wr_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_datain_q;

  logic [31:0]      merged_d;
  logic             req_bad_d;

  assign req_bad_d = request_misaligned(store_size_t'(size), addr[1:0]);

  byte_merge u_merge (
    .old_word (mem_dataout),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (offset_q),
    .merged   (merged_d)
  );

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= SZ_BYTE;
      offset_q     <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            size_q   <= store_size_t'(size);
            offset_q <= addr[1:0];
            wdata_q  <= wdata;
            busy_q   <= 1'b1;
            if (req_bad_d) begin
              state_q      <= ERR;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else if (store_size_t'(size) == SZ_WORD) begin
              state_q      <= WRITE;
              mem_addr_q   <= word_align(addr);
              mem_wr_q     <= 1'b1;
              mem_datain_q <= wdata;
            end else begin
              state_q    <= READ;
              mem_addr_q <= word_align(addr);
            end
          end
        end
        READ: begin
          state_q <= WAIT;
          cnt_q   <= WAIT_LAST;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= WRITE;
            mem_wr_q     <= 1'b1;
            mem_datain_q <= merged_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WRITE: begin
          state_q      <= DONE;
          done_q       <= 1'b1;
          mem_addr_q   <= '0;
          mem_datain_q <= '0;
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          mem_addr_q   <= '0;
          mem_datain_q <= '0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_datain = mem_datain_q;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side companion to the CPU's read-only memory port; executes sw/sh/sb against the 32-bit-wide Memoria block.
- Word stores write directly. Byte and halfword stores do a read-modify-write: read the aligned word, merge the lane(s), write back.
- Sits between the control unit and Memoria; the control unit pulses start and stalls until done.

Parameters:
- MEM_LATENCY, 1, cycles from address presented (mem_wr=0) to valid mem_dataout; legal range 1..4.

Ports:
- clock       in   1   system clock
- reset       in   1   synchronous, active-high reset
- start       in   1   request strobe; sampled only in IDLE
- size        in   2   00=byte, 01=half, 10=word, 11=reserved
- addr        in   32  byte address of the store
- wdata       in   32  store data, right-justified (byte in [7:0], half in [15:0])
- busy        out  1   high in every state except IDLE
- done        out  1   one-cycle completion pulse
- misaligned  out  1   valid with done; 1 = request rejected, memory untouched
- mem_addr    out  32  word-aligned address to Memoria
- mem_wr      out  1   Memoria write strobe
- mem_datain  out  32  write data to Memoria
- mem_dataout in   32  read data from Memoria

Behaviour:
- Reset, applied at any edge and in any state: state=IDLE; busy=0, done=0, misaligned=0, mem_wr=0, mem_addr=0, mem_datain=0; internal registers cleared. A reset mid-RMW abandons the store; no write occurs after reset.
- Byte lanes are little-endian: offset 0 maps to [7:0], 1 to [15:8], 2 to [23:16], 3 to [31:24].
- IDLE, on start=1, latches addr, size and wdata, then checks the request:
  - size=11 -> ERR
  - half with addr[0]=1 -> ERR
  - word with addr[1:0]!=0 -> ERR
  - word, aligned -> WRITE
  - byte or half, aligned -> READ
- READ, 1 cycle: mem_addr={a[31:2],2'b00}, mem_wr=0. Next state WAIT.
- WAIT, MEM_LATENCY cycles, counted with a down-counter: mem_addr held, mem_wr=0. At the edge ending the last WAIT cycle, mem_dataout is captured and merged.
  - Byte: replace lane a[1:0] with wdata[7:0].
  - Half: replace lanes a[1]*2 and a[1]*2+1 with wdata[15:0].
- WRITE, 1 cycle: mem_addr=aligned address, mem_wr=1, mem_datain = wdata (word) or the merged word (byte/half). Next state DONE.
- DONE, 1 cycle: done=1, misaligned=0, then IDLE.
- ERR, 1 cycle: done=1, misaligned=1, mem_wr=0, then IDLE.
- Outside READ/WAIT/WRITE: mem_addr=0, mem_datain=0, mem_wr=0.
- Latency, counted as edges from the start-sampling edge to the done cycle:
  - word: 2 (WRITE, DONE)
  - byte/half: 3+MEM_LATENCY (READ, WAIT×L, WRITE, DONE)
  - error: 1
- start while busy is ignored and not queued. start may be asserted in the DONE cycle, but it is only accepted in the following IDLE cycle.
- All outputs come from state registers. There is no combinational path from start to mem_wr.
- mem_wr is high for exactly one cycle per accepted, aligned store.

Decomposition:
- Shared package store_pkg:
  - typedef enum logic[1:0] store_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}
  - typedef enum logic[2:0] store_state_t {IDLE, READ, WAIT, WRITE, DONE, ERR}
  - MEM_LATENCY_MAX=4
- One combinational sub-module, byte_merge: inputs old word, wdata, size, offset; output merged word. It is verified standalone over all size/offset pairs.

Test Plan:
- Reset, then sw addr=0x40, wdata=0xDEADBEEF -> mem_wr=1 on edge+1 with mem_addr=0x40, mem_datain=0xDEADBEEF; done on edge+2; misaligned=0.
- Memory[0x40]=0x11223344, sb addr=0x42, wdata=0x000000AA, L=1 -> read of 0x40; write of 0x11AA3344 on edge+3; done on edge+4.
- Memory[0x40]=0x11223344, sh addr=0x42, wdata=0x0000BEEF -> writes 0xBEEF3344. Repeat with MEM_LATENCY=3 -> done on edge+6.
- sw addr=0x41; sh addr=0x43; size=11 -> done with misaligned=1 on edge+1; mem_wr never asserted.
- Second start held during busy -> ignored, exactly one mem_wr. Back-to-back stores with start re-asserted in the DONE cycle -> second store accepted in the following IDLE cycle.
- reset asserted in a WAIT cycle of an sb -> next cycle IDLE, all outputs 0, no mem_wr, memory unchanged.
